// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Pointer width is log2(DEPTH)+1 so the wrap bit can tell full from empty.
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a FIFO and its producer/consumer side.
// The master side drives requests; the FIFO sits on the slave side.
interface sync_fifo_param_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
);
    localparam int PW = fifo_pkg::ptr_w(DEPTH);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [PW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, never reset.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy flags, sticky error flags,
// synchronous flush and a selectable registered or fall-through read port.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = FIFO_MODE_REG
) (
    input  logic                CLK,
    input  logic                RESET,
    sync_fifo_param_if.slave    bus
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0]    wptr, rptr, occ;
    logic             full_w, empty_w;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] mem_rdata;
    int               occ_i;

    // Wrap bits differ with equal addresses only when DEPTH entries are held.
    assign empty_w = (wptr == rptr);
    assign full_w  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign occ     = wptr - rptr;
    assign occ_i   = int'(occ);

    assign wr_acc = bus.wr_en && !full_w  && !bus.flush;
    assign rd_acc = bus.rd_en && !empty_w && !bus.flush;

    fifo_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .CLK   (CLK),
        .we    (wr_acc),
        .waddr (wptr[AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (rptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wptr <= '0;
            rptr <= '0;
        end else if (bus.flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
        end
    end

    // Errors are judged on the pre-edge flags; a new error beats clr_err.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (bus.wr_en && full_w)       bus.overflow <= 1'b1;
            else if (bus.clr_err)          bus.overflow <= 1'b0;
            if (bus.rd_en && empty_w)      bus.underflow <= 1'b1;
            else if (bus.clr_err)          bus.underflow <= 1'b0;
        end
    end

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.count        = occ;
    assign bus.almost_full  = (occ_i >= AF_THRESH);
    assign bus.almost_empty = (occ_i <= AE_THRESH);

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign bus.rd_data  = mem_rdata;
            assign bus.rd_valid = !empty_w;
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_vld_q;

            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    rd_data_q <= '0;
                    rd_vld_q  <= 1'b0;
                end else begin
                    rd_vld_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem_rdata;
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a registered-read and a FWFT FIFO with identical stimulus and
// checks both against a queue-based reference model.
module tb_sync_fifo_param;
    import fifo_pkg::*;

    localparam int W = 16;
    localparam int D = 8;

    logic CLK = 1'b0;
    logic RESET;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 CLK = ~CLK;

    sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) ifa ();
    sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) ifb ();

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(1),
                      .FWFT(FIFO_MODE_REG)) u_reg (.CLK(CLK), .RESET(RESET), .bus(ifa));
    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(1),
                      .FWFT(FIFO_MODE_FWFT)) u_fwft (.CLK(CLK), .RESET(RESET), .bus(ifb));

    // Reference model state
    logic [W-1:0] q[$];
    bit           m_ovf, m_udf, m_rv;
    logic [W-1:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("reg.count",  32'(ifa.count), n);
        chk("reg.empty",  32'(ifa.empty), 32'(n == 0));
        chk("reg.full",   32'(ifa.full),  32'(n == D));
        chk("reg.afull",  32'(ifa.almost_full),  32'(n >= 6));
        chk("reg.aempty", 32'(ifa.almost_empty), 32'(n <= 1));
        chk("reg.ovf",    32'(ifa.overflow),  32'(m_ovf));
        chk("reg.udf",    32'(ifa.underflow), 32'(m_udf));
        chk("reg.rvalid", 32'(ifa.rd_valid),  32'(m_rv));
        chk("reg.rdata",  32'(ifa.rd_data),   32'(m_rd));
        chk("fwft.count", 32'(ifb.count), n);
        chk("fwft.empty", 32'(ifb.empty), 32'(n == 0));
        chk("fwft.full",  32'(ifb.full),  32'(n == D));
        chk("fwft.ovf",   32'(ifb.overflow),  32'(m_ovf));
        chk("fwft.udf",   32'(ifb.underflow), 32'(m_udf));
        chk("fwft.rvalid", 32'(ifb.rd_valid), 32'(n != 0));
        if (n != 0) chk("fwft.rdata", 32'(ifb.rd_data), 32'(q[0]));
    endtask

    task automatic step(input bit rst, input bit wr, input logic [W-1:0] wd,
                        input bit rd, input bit fl, input bit ce);
        bit was_full, was_empty;
        RESET = rst;
        ifa.wr_en = wr; ifa.wr_data = wd; ifa.rd_en = rd; ifa.flush = fl; ifa.clr_err = ce;
        ifb.wr_en = wr; ifb.wr_data = wd; ifb.rd_en = rd; ifb.flush = fl; ifb.clr_err = ce;
        @(posedge CLK);
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        if (!rst) begin
            q.delete();
            m_ovf = 0; m_udf = 0; m_rv = 0; m_rd = '0;
        end else begin
            if (wr && was_full) m_ovf = 1; else if (ce) m_ovf = 0;
            if (rd && was_empty) m_udf = 1; else if (ce) m_udf = 0;
            m_rv = 0;
            if (fl) q.delete();
            else begin
                if (rd && !was_empty) begin m_rd = q.pop_front(); m_rv = 1; end
                if (wr && !was_full) q.push_back(wd);
            end
        end
        #1;
        check_all();
    endtask

    task automatic push(input logic [W-1:0] d); step(1, 1, d, 0, 0, 0); endtask
    task automatic pop();  step(1, 0, '0, 1, 0, 0); endtask

    initial begin
        m_rd = '0;
        step(0, 0, '0, 0, 0, 0);
        step(0, 1, 16'h1234, 1, 0, 0);
        chk("reset.rdata", 32'(ifa.rd_data), 32'h0);
        chk("reset.aempty", 32'(ifa.almost_empty), 32'h1);

        // Fill then drain
        for (int i = 1; i <= 8; i++) push(W'(i));
        chk("fill.full", 32'(ifa.full), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            pop();
            chk("drain.order", 32'(ifa.rd_data), 32'(i));
        end
        chk("drain.empty", 32'(ifa.empty), 32'h1);

        // Wrap-around
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) push(W'($urandom));
            for (int i = 0; i < 5; i++) pop();
        end

        // Contention at full, then at empty
        for (int i = 0; i < 8; i++) push(W'(16'h0100 + i));
        step(1, 1, 16'hBEEF, 1, 0, 0);
        chk("full.both.count", 32'(ifa.count), 32'd7);
        chk("full.both.ovf", 32'(ifa.overflow), 32'h1);
        for (int i = 0; i < 7; i++) pop();
        step(1, 1, 16'h5A5A, 1, 0, 0);
        chk("empty.both.count", 32'(ifa.count), 32'd1);
        chk("empty.both.udf", 32'(ifa.underflow), 32'h1);
        pop();
        step(1, 0, '0, 0, 0, 1);

        // Thresholds across 0..8
        for (int i = 0; i < 8; i++) push(W'($urandom));
        for (int i = 0; i < 8; i++) pop();

        // FWFT fall-through of a single word
        push(16'h00A5);
        chk("fwft.a5.valid", 32'(ifb.rd_valid), 32'h1);
        chk("fwft.a5.data", 32'(ifb.rd_data), 32'h00A5);
        pop();
        chk("fwft.a5.empty", 32'(ifb.empty), 32'h1);

        // Flush keeps error flags
        for (int i = 0; i < 9; i++) push(W'(16'h0200 + i));
        for (int i = 0; i < 4; i++) pop();
        step(1, 1, 16'hCAFE, 0, 1, 0);
        chk("flush.count", 32'(ifa.count), 32'd0);
        chk("flush.ovf", 32'(ifa.overflow), 32'h1);
        step(1, 0, '0, 0, 0, 1);
        chk("clr.ovf", 32'(ifa.overflow), 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1, $urandom_range(0, 99) < 55, W'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);

        // Reset mid-burst
        for (int i = 0; i < 3; i++) push(W'($urandom));
        step(0, 1, 16'h7777, 1, 0, 0);
        chk("midrst.count", 32'(ifa.count), 32'd0);
        chk("midrst.rvalid", 32'(ifa.rd_valid), 32'h0);
        step(1, 0, '0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO. Next generation of the 8-deep, 1-bit symbol buffer that sits between the bit source and the modulator datapath.
- Generalised in data width and depth. Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Selectable read mode: registered output or first-word-fall-through (FWFT).

Parameters:
- WIDTH, 1, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- Derived constant AW = log2(DEPTH). Pointers and count are AW+1 bits.

Ports:
- CLK, input, 1, clock; all logic on the rising edge.
- RESET, input, 1, reset, synchronous, active-low.
- flush, input, 1, synchronous clear of contents; error flags are kept.
- wr_en, input, 1, write request.
- wr_data, input, WIDTH, write data.
- rd_en, input, 1, read request (pop).
- rd_data, output, WIDTH, read data.
- rd_valid, output, 1, rd_data is valid.
- full, output, 1, FIFO holds DEPTH entries.
- empty, output, 1, FIFO holds 0 entries.
- almost_full, output, 1, count >= AF_THRESH.
- almost_empty, output, 1, count <= AE_THRESH.
- count, output, AW+1, current occupancy, 0..DEPTH.
- overflow, output, 1, sticky: a write was attempted while full.
- underflow, output, 1, sticky: a read was attempted while empty.
- clr_err, input, 1, clears overflow and underflow.

Behaviour:
- Pointers:
  - wptr and rptr are AW+1 bits; the low AW bits address storage, the MSB is a wrap bit.
  - empty = (wptr == rptr).
  - full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]).
  - count = wptr - rptr, modulo 2^(AW+1).
  - Pointers wrap naturally; no explicit compare-and-clear.
- Write: accepted iff wr_en && !full. Storage is written at wptr and wptr increments on the same edge.
- Read: accepted iff rd_en && !empty. rptr increments on the same edge.
- Simultaneous read and write:
  - Each is evaluated against the pre-edge flags.
  - When full: the read is accepted, the write is rejected, and overflow sets.
  - When empty: the write is accepted, the read is rejected, and underflow sets.
  - Otherwise both are accepted and count is unchanged.
- FWFT=0:
  - rd_data is registered and loads mem[rptr] on an accepted read.
  - rd_valid pulses high exactly one cycle after each accepted read, otherwise 0. Latency is 1 cycle.
  - rd_data holds its last value when no read occurs.
- FWFT=1:
  - rd_data = mem[rptr] combinationally; rd_valid = !empty.
  - An accepted rd_en consumes the displayed word.
  - Write-to-rd_valid latency is 1 cycle; storage is never bypassed.
- Flags:
  - full, empty, almost_full, almost_empty and count are all combinational from the pointers.
  - They update the cycle after the accepting edge.
- Errors:
  - overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - Both flags stay set until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, set wins.
- flush:
  - wptr and rptr clear to 0, and rd_valid goes to 0.
  - Takes priority over wr_en and rd_en in the same cycle.
  - Storage contents are not cleared.
- Reset (RESET=0 at the edge):
  - wptr=0, rptr=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Therefore empty=1, full=0, count=0, almost_empty=1, and almost_full=(AF_THRESH==0 ? 1 : 0), i.e. 0 with the legal range.
  - Reset mid-operation discards all contents with no partial update.
- Storage is not reset.

Decomposition:
- Shared package (fifo_pkg): clog2 constant function, pointer-width derivation, FWFT mode constants (FIFO_MODE_REG=0, FIFO_MODE_FWFT=1).
- One sub-module, fifo_regfile: DEPTH x WIDTH storage with a synchronous write port and an asynchronous read port.
- Pointer, flag, error and output-mode logic stays in sync_fifo_param.

Test Plan (WIDTH=16, DEPTH=8, AF_THRESH=6, AE_THRESH=1 unless stated):
- Fill then drain. Write 0x0001..0x0008, then read 8 times. Expect full=1 after the 8th write and count=8. Reads return 0x0001..0x0008 in order, rd_valid one cycle after each rd_en. Ends with empty=1.
- Wrap-around. Repeat 3 cycles of 5 writes then 5 reads. Data is preserved in order across the pointer wrap; count never exceeds 5; full is never asserted.
- Boundary contention:
  - At full: wr_en+rd_en with data 0xBEEF. Read accepted, 0xBEEF dropped, overflow=1, count=7.
  - At empty: wr_en+rd_en. Write accepted, underflow=1, count=1.
- Thresholds. Step count 0..8. almost_empty=1 for count<=1; almost_full=1 for count>=6.
- FWFT=1. Write 0x00A5 to an empty FIFO. Next cycle rd_valid=1 and rd_data=0x00A5 with no rd_en. Pop gives empty=1.
- Flush and reset:
  - With count=4 and overflow=1, assert flush with wr_en. Expect count=0, empty=1, overflow still 1. clr_err then clears it.
  - RESET=0 mid-burst clears all outputs to their reset values.
